// File: rtl/scroll_engine.sv
// scroll_engine: rotating display pattern with a prescaled step timer,
// direction control, parallel load and a saturating speed register.
module scroll_engine #(
    parameter int WIDTH      = 32,
    parameter int STEP       = 4,
    parameter int SPEED_W    = 8,
    parameter int SPEED_MIN  = 10,
    parameter int SPEED_MAX  = 100,
    parameter int SPEED_DEF  = 50,
    parameter int SPEED_STEP = 10,
    parameter int PRESCALE   = 50000
) (
    input  logic               clock,
    input  logic               resetn,     // synchronous, active-high despite the name
    input  logic               enable,
    input  logic               dir,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               speedup,
    input  logic               speeddown,
    output logic [WIDTH-1:0]   Q,
    output logic [SPEED_W-1:0] speed,
    output logic               step,
    output logic               running
);

    // Speed arithmetic carries one spare bit so that sums and differences
    // can be range-checked before being narrowed back to SPEED_W.
    localparam int SW   = SPEED_W + 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [SW-1:0]      LP_MIN     = SW'(SPEED_MIN);
    localparam logic [SW-1:0]      LP_MAX     = SW'(SPEED_MAX);
    localparam logic [SW-1:0]      LP_STEP    = SW'(SPEED_STEP);
    localparam logic [SPEED_W-1:0] LP_DEF     = SPEED_W'(SPEED_DEF);
    localparam logic [PS_W-1:0]    LP_PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PS_W-1:0]      r_ps_cnt;
    logic [SW-1:0]        r_step_cnt;
    logic [WIDTH-1:0]     r_q;
    logic [SPEED_W-1:0]   r_speed;
    logic                 r_step;
    logic                 r_running;

    logic                 w_tick;
    logic [SW-1:0]        w_interval_m1;
    logic                 w_due;
    logic                 w_rotate;
    logic                 w_counting;
    logic [WIDTH-1:0]     w_rotated;
    logic [SW-1:0]        w_speed_sum;
    logic [SW-1:0]        w_speed_diff;
    logic [SPEED_W-1:0]   w_speed_next;

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (resetn) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic: RUN follows enable.
    always_comb begin
        // NOTE: default assigned first so no path through this block leaves
        // the output unassigned, which would infer a latch.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (enable)  w_state_next = ST_RUN;
            ST_RUN:  if (!enable) w_state_next = ST_IDLE;
            default:              w_state_next = ST_IDLE;
        endcase
    end

    // Timer decode: a tick ends each prescale period, a step is due once the
    // tick count reaches the current interval (>= so a faster speed never
    // lets the count run past the threshold).
    assign w_tick        = (r_state == ST_RUN) && (r_ps_cnt == LP_PS_LAST);
    assign w_interval_m1 = LP_MAX - {1'b0, r_speed};
    assign w_due         = w_tick && (r_step_cnt >= w_interval_m1);
    assign w_rotate      = w_due && !load;   // a load swallows a due step
    // Counters only advance while RUN persists; IDLE, leaving RUN and load
    // all force them back to zero so the next run restarts from a clean count.
    assign w_counting    = (r_state == ST_RUN) && (w_state_next == ST_RUN) && !load;
    assign w_rotated     = dir ? {r_q[STEP-1:0], r_q[WIDTH-1:STEP]}
                               : {r_q[WIDTH-STEP-1:0], r_q[WIDTH-1:WIDTH-STEP]};

    // Prescale and step counters.
    always_ff @(posedge clock) begin
        if (resetn || !w_counting) begin
            r_ps_cnt   <= '0;
            r_step_cnt <= '0;
        end else if (w_tick) begin
            r_ps_cnt   <= '0;
            r_step_cnt <= w_due ? '0 : r_step_cnt + SW'(1);
        end else begin
            r_ps_cnt   <= r_ps_cnt + PS_W'(1);
        end
    end

    // Pattern register and step pulse; load outranks rotation.
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_q    <= '0;
            r_step <= 1'b0;
        end else begin
            r_step <= w_rotate;
            if (load)          r_q <= load_data;
            else if (w_rotate) r_q <= w_rotated;
        end
    end

    // Saturating speed update; a wrapped difference shows up in the spare
    // top bit, which catches underflow before the minimum clamp.
    assign w_speed_sum  = {1'b0, r_speed} + LP_STEP;
    assign w_speed_diff = {1'b0, r_speed} - LP_STEP;

    always_comb begin
        w_speed_next = r_speed;
        if (speedup && !speeddown) begin
            w_speed_next = (w_speed_sum > LP_MAX) ? LP_MAX[SPEED_W-1:0]
                                                  : w_speed_sum[SPEED_W-1:0];
        end else if (speeddown && !speedup) begin
            w_speed_next = (w_speed_diff[SW-1] || (w_speed_diff < LP_MIN))
                         ? LP_MIN[SPEED_W-1:0] : w_speed_diff[SPEED_W-1:0];
        end
    end

    // Speed and running registers.
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_speed   <= LP_DEF;
            r_running <= 1'b0;
        end else begin
            r_speed   <= w_speed_next;
            r_running <= (w_state_next == ST_RUN);
        end
    end

    assign Q       = r_q;
    assign speed   = r_speed;
    assign step    = r_step;
    assign running = r_running;

endmodule

// File: doc/scroll_engine.md
# scroll_engine

Parametrised scrolling-pattern engine for the display path. Holds a WIDTH-bit pattern and rotates it by STEP bits at a runtime-adjustable rate set by speed-up/speed-down pulses. Adds a prescaled step timer, direction control, parallel load and saturating speed limits. Its output Q drives the 7-segment/LED register downstream.

## Interface
- WIDTH, 32: pattern width in bits; must be a multiple of STEP.
- STEP, 4: bits rotated per scroll step (4 = one hex digit).
- SPEED_W, 8: speed register width.
- SPEED_MIN, 10: lowest speed value.
- SPEED_MAX, 100: highest speed value; must be less than 2^SPEED_W.
- SPEED_DEF, 50: speed after reset; SPEED_MIN ≤ SPEED_DEF ≤ SPEED_MAX.
- SPEED_STEP, 10: increment or decrement applied per speed pulse.
- PRESCALE, 50000: clocks per tick; ≥1.
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  reset; synchronous, active-high despite the name.
- enable  in  1  1 = scroll running, 0 = hold.
- dir  in  1  0 = rotate left (toward MSB), 1 = rotate right.
- load  in  1  one-cycle strobe; loads load_data into the pattern.
- load_data  in  WIDTH  pattern value to load.
- speedup  in  1  one-cycle pulse that raises speed.
- speeddown  in  1  one-cycle pulse that lowers speed.
- Q  out  WIDTH  current pattern (registered).
- speed  out  SPEED_W  current speed (registered).
- step  out  1  one-cycle pulse on the edge where Q rotates.
- running  out  1  1 when the FSM is in RUN.

## Operation
- Reset values: Q=0, speed=SPEED_DEF, step=0, running=0, state=IDLE, prescale count=0, step count=0.
- Priority, highest first: resetn, then load, then rotation. Speed update is independent of all three except reset.
- FSM states:
  - IDLE → RUN when enable=1.
  - RUN → IDLE when enable=0.
  - In IDLE, the prescale and step counters are held at 0 and Q holds.
  - running=1 exactly when the state is RUN.
- Prescaler:
  - In RUN it counts 0..PRESCALE-1 and wraps.
  - tick=1 in a cycle where the count is PRESCALE-1.
  - With PRESCALE=1, tick=1 in every RUN cycle.
- Interval: INTERVAL = SPEED_MAX − speed + 1 ticks. This gives 1 at maximum speed and SPEED_MAX−SPEED_MIN+1 at minimum speed.
- Step counter, on each tick in RUN:
  - If step_cnt ≥ INTERVAL−1: rotate Q, pulse step, set step_cnt=0.
  - Otherwise: increment step_cnt.
  - Using ≥ means a speed increase mid-count never skips past the threshold.
- Rotation:
  - Left: Q ← {Q[WIDTH−STEP−1:0], Q[WIDTH−1:WIDTH−STEP]}.
  - Right: Q ← {Q[STEP−1:0], Q[WIDTH−1:STEP]}.
  - dir is sampled on the step edge only.
- Speed arithmetic is done at SPEED_W+1 bits:
  - speedup only: speed ← min(speed+SPEED_STEP, SPEED_MAX).
  - speeddown only: speed ← max(speed−SPEED_STEP, SPEED_MIN), with no underflow.
  - Both, or neither: no change.
  - Speed updates in any FSM state.
- load:
  - Q ← load_data.
  - Both counters cleared.
  - No step pulse in that cycle, even if the step threshold was reached.
  - The state is unchanged.
- Reset mid-run: every register returns to its reset value on the next edge, including speed.

## Timing
- Q, speed, step and running are all registered; no combinational path from inputs to outputs.
- Speed change is visible on the edge after the pulse. The new INTERVAL applies from the following cycle.
- First step: with enable sampled high at edge k (IDLE→RUN), the first rotation occurs at edge k + INTERVAL·PRESCALE. Subsequent steps follow every INTERVAL·PRESCALE clocks.
- step is high for exactly one cycle, coincident with the cycle in which the new Q is first visible.
- A load at edge j restarts timing: the next step falls at edge j + INTERVAL·PRESCALE.
- When enable drops, the state is IDLE after that edge and no further steps occur. Re-enabling restarts the count from 0.

## Test plan
All scenarios use defaults except PRESCALE=1, and assert resetn before each scenario.
- Reset: resetn=1 for 2 cycles → Q=0, speed=50, step=0, running=0.
- Left scroll:
  - Stimulus: load 0x12345678, enable=1, dir=0.
  - Required: Q=0x23456781 exactly 51 clocks after entering RUN; Q=0x34567812 51 clocks later; step pulses once per step.
- Right scroll: same load with dir=1 → first step gives Q=0x81234567.
- Saturation up:
  - Stimulus: six speedup pulses.
  - Required: speed reads 60, 70, 80, 90, 100, 100 after the successive pulses; interval becomes 1 (step every RUN cycle).
- Saturation down:
  - Stimulus: ten speeddown pulses from 50.
  - Required: speed floors at 10; step spacing is 91 clocks.
- Edge cases:
  - speedup and speeddown in the same cycle → speed unchanged.
  - load on the same edge as a due step → Q=load_data and no step pulse.
  - resetn asserted mid-run → all outputs return to their reset values on the next edge.
